// File: rtl/branch_resolve_ctrl.sv
// rtl/branch_resolve_ctrl.sv - branch direction predictor and mispredict recovery sequencer
module branch_resolve_ctrl #(
   parameter int INDEX_W        = 6,
   parameter int RECOVER_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        pred_taken,
   input  logic        ex_valid,
   input  logic        ex_stall,
   input  logic        ex_branch,
   input  logic        ex_jump,
   input  logic        ex_taken,
   input  logic [31:0] ex_pc,
   input  logic [31:0] ex_target,
   input  logic        ex_pred_taken,
   input  logic [31:0] ex_pred_target,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        flush_if_id,
   output logic        flush_id_ex,
   output logic        busy,
   output logic [31:0] mispredict_count
);

   localparam int BHT_N = 1 << INDEX_W;
   localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REDIRECT,
      S_RECOVER
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   rec_cnt, rec_cnt_nxt;
   logic [1:0]         bht [BHT_N];
   logic [INDEX_W-1:0] if_idx, ex_idx;
   logic [1:0]         bht_cur, bht_new;
   logic               res, mispredict, bht_we;
   logic [31:0]        corr_pc;
   logic               unused_pc_bits;

   assign if_idx         = if_pc[INDEX_W+1:2];
   assign ex_idx         = ex_pc[INDEX_W+1:2];
   assign pred_taken     = bht[if_idx][1];
   assign bht_cur        = bht[ex_idx];
   assign unused_pc_bits = ^{if_pc[31:INDEX_W+2], if_pc[1:0]};

   // Pulses and busy decode straight from the state register, so they trail the resolution by one cycle.
   assign redirect_valid = (state == S_REDIRECT);
   assign flush_if_id    = (state == S_REDIRECT);
   assign flush_id_ex    = (state == S_REDIRECT);
   assign busy           = (state != S_IDLE);

   // Qualify the EX resolution, detect a mispredict, and pick the next state and BHT write.
   always_comb begin
      state_nxt   = state;
      rec_cnt_nxt = rec_cnt;
      res         = ex_valid & ~ex_stall & (ex_branch | ex_jump) & (state == S_IDLE);
      mispredict  = res & ((ex_taken != ex_pred_taken) |
                           (ex_taken & ex_pred_taken & (ex_target != ex_pred_target)));
      corr_pc     = ex_taken ? ex_target : (ex_pc + 32'd4);
      // A branch+jump combination is treated as a jump, which never trains the table.
      bht_we      = res & ex_branch & ~ex_jump;
      bht_new     = bht_cur;
      if (ex_taken) begin
         if (bht_cur != 2'b11) bht_new = bht_cur + 2'b01;
      end else begin
         if (bht_cur != 2'b00) bht_new = bht_cur - 2'b01;
      end
      case (state)
         S_IDLE: begin
            if (mispredict) state_nxt = S_REDIRECT;
         end
         S_REDIRECT: begin
            if (RECOVER_CYCLES > 0) begin
               state_nxt   = S_RECOVER;
               rec_cnt_nxt = CNT_W'(RECOVER_CYCLES);
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_RECOVER: begin
            if (rec_cnt <= CNT_W'(1)) state_nxt = S_IDLE;
            else                      rec_cnt_nxt = rec_cnt - CNT_W'(1);
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, recovery counter, corrected PC and mispredict tally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= S_IDLE;
         rec_cnt          <= '0;
         redirect_pc      <= '0;
         mispredict_count <= '0;
      end else begin
         state   <= state_nxt;
         rec_cnt <= rec_cnt_nxt;
         if (mispredict) begin
            redirect_pc      <= corr_pc;
            mispredict_count <= mispredict_count + 32'd1;
         end
      end
   end

   // Branch history table; written at the edge so same-cycle lookups see the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
      end else if (bht_we) begin
         bht[ex_idx] <= bht_new;
      end
   end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb/tb_branch_resolve_ctrl.sv - self-checking bench for branch_resolve_ctrl
module tb_branch_resolve_ctrl;

   localparam int IW = 6;
   localparam int RC = 1;
   localparam int N  = 1 << IW;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic        ex_valid, ex_stall, ex_branch, ex_jump, ex_taken, ex_pred_taken;
   logic [31:0] ex_pc, ex_target, ex_pred_target;
   logic        redirect_valid, flush_if_id, flush_id_ex, busy;
   logic [31:0] redirect_pc, mispredict_count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int          m_bht [N];
   int          m_busy_left;
   bit          m_pulse;
   logic [31:0] m_pc;
   logic [31:0] m_count;

   always #5 clk = ~clk;

   branch_resolve_ctrl #(.INDEX_W(IW), .RECOVER_CYCLES(RC)) dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
      .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_taken(ex_taken), .ex_pc(ex_pc), .ex_target(ex_target),
      .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .busy(busy), .mispredict_count(mispredict_count)
   );

   function automatic bit m_pred(input logic [31:0] pc);
      return m_bht[int'((pc >> 2) & (N - 1))] >= 2;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_bht[i] = 1;
      m_busy_left = 0;
      m_pulse     = 0;
      m_pc        = '0;
      m_count     = '0;
   endtask

   // One clock edge of the architectural behaviour, evaluated from the inputs present at the edge.
   task automatic model_step();
      bit          res, mis;
      int          idx;
      logic [31:0] p4;
      res = ex_valid && !ex_stall && (ex_branch || ex_jump) && (m_busy_left == 0);
      mis = res && ((ex_taken != ex_pred_taken) ||
                    (ex_taken && ex_pred_taken && ex_target != ex_pred_target));
      if (res && ex_branch && !ex_jump) begin
         idx = int'((ex_pc >> 2) & (N - 1));
         if (ex_taken) m_bht[idx] = (m_bht[idx] >= 3) ? 3 : m_bht[idx] + 1;
         else          m_bht[idx] = (m_bht[idx] <= 0) ? 0 : m_bht[idx] - 1;
      end
      if (mis) begin
         p4          = ex_pc + 32'd4;
         m_pulse     = 1;
         m_pc        = ex_taken ? ex_target : p4;
         m_count     = m_count + 32'd1;
         m_busy_left = 1 + RC;
      end else begin
         m_pulse = 0;
         if (m_busy_left > 0) m_busy_left--;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic clear_ex();
      ex_valid = 0; ex_stall = 0; ex_branch = 0; ex_jump = 0; ex_taken = 0;
      ex_pc = '0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
   endtask

   task automatic set_ex(input bit v, input bit st, input bit br, input bit jp, input bit tk,
                         input logic [31:0] pc, input logic [31:0] tgt,
                         input bit ptk, input logic [31:0] ptgt);
      ex_valid = v; ex_stall = st; ex_branch = br; ex_jump = jp; ex_taken = tk;
      ex_pc = pc; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
   endtask

   task automatic test_reset();
      rst_n = 0;
      clear_ex();
      if_pc = 32'h100;
      model_reset();
      #3;
      n_checks++;
      if (pred_taken !== 1'b0) begin
         n_fail++; $display("FAIL reset_pred_taken: got %b expected 0", pred_taken);
      end
      n_checks++;
      if ({redirect_valid, flush_if_id, flush_id_ex, busy} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags: got %b expected 0000",
                            {redirect_valid, flush_if_id, flush_id_ex, busy});
      end
      n_checks++;
      if (redirect_pc !== 32'h0 || mispredict_count !== 32'h0) begin
         n_fail++; $display("FAIL reset_regs: got pc=%h cnt=%0d expected 0/0", redirect_pc, mispredict_count);
      end
      @(posedge clk);
      #1 rst_n = 1;
      cycle();
   endtask

   task automatic test_beq_mispredict();
      int bc;
      set_ex(1, 0, 1, 0, 1, 32'h200, 32'h180, 0, 32'h0);
      cycle();
      clear_ex();
      n_checks++;
      if ({redirect_valid, flush_if_id, flush_id_ex, busy} !== 4'b1111) begin
         n_fail++; $display("FAIL beq_pulse: got %b expected 1111",
                            {redirect_valid, flush_if_id, flush_id_ex, busy});
      end
      n_checks++;
      if (redirect_pc !== 32'h180 || mispredict_count !== 32'd1) begin
         n_fail++; $display("FAIL beq_pc_cnt: got pc=%h cnt=%0d expected 180/1", redirect_pc, mispredict_count);
      end
      bc = 1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (i == 0) begin
            n_checks++;
            if ({redirect_valid, flush_if_id, flush_id_ex} !== 3'b000 || redirect_pc !== 32'h180) begin
               n_fail++; $display("FAIL beq_pulse_drop: got %b pc=%h expected 000 pc=180",
                                  {redirect_valid, flush_if_id, flush_id_ex}, redirect_pc);
            end
         end
         if (!busy) break;
         bc++;
      end
      n_checks++;
      if (bc != 1 + RC) begin
         n_fail++; $display("FAIL beq_busy_len: got %0d expected %0d", bc, 1 + RC);
      end
   endtask

   task automatic test_bht_train();
      if_pc = 32'h40;
      for (int k = 0; k < 4; k++) begin
         set_ex(1, 0, 1, 0, 1, 32'h40, 32'h60, 1, 32'h60);
         #1;
         n_checks++;
         if (pred_taken !== m_pred(32'h40)) begin
            n_fail++; $display("FAIL train_pre_%0d: got %b expected %b", k, pred_taken, m_pred(32'h40));
         end
         cycle();
         n_checks++;
         if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL train_noredir_%0d: got rv=%b busy=%b expected 0/0", k, redirect_valid, busy);
         end
      end
      clear_ex();
      #1;
      n_checks++;
      if (pred_taken !== 1'b1) begin
         n_fail++; $display("FAIL train_final: got %b expected 1", pred_taken);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] cnt_after;
      set_ex(1, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'h1000, 1, 32'h1000);
      cycle();
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
         n_fail++; $display("FAIL wrap_pc: got rv=%b pc=%h expected 1/00000000", redirect_valid, redirect_pc);
      end
      cnt_after = m_count;
      for (int j = 0; j < 1 + RC; j++) begin
         set_ex(1, 0, 1, 0, 0, 32'h40, 32'h80, 1, 32'h80);
         cycle();
         n_checks++;
         if (redirect_valid !== 1'b0 || mispredict_count !== cnt_after) begin
            n_fail++; $display("FAIL squash_%0d: got rv=%b cnt=%0d expected 0/%0d",
                               j, redirect_valid, mispredict_count, cnt_after);
         end
      end
      clear_ex();
      if_pc = 32'h40;
      #1;
      n_checks++;
      if (pred_taken !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL squash_bht: got pred=%b busy=%b expected 1/0", pred_taken, busy);
      end
   endtask

   task automatic test_jal();
      if_pc = 32'h80;
      set_ex(1, 0, 0, 1, 1, 32'h80, 32'h340, 1, 32'h300);
      cycle();
      clear_ex();
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h340 || mispredict_count !== m_count) begin
         n_fail++; $display("FAIL jal_redirect: got rv=%b pc=%h cnt=%0d expected 1/340/%0d",
                            redirect_valid, redirect_pc, mispredict_count, m_count);
      end
      n_checks++;
      if (pred_taken !== 1'b0) begin
         n_fail++; $display("FAIL jal_bht: got %b expected 0", pred_taken);
      end
      repeat (1 + RC) cycle();
   endtask

   task automatic test_stall();
      int pulses;
      set_ex(1, 1, 1, 0, 1, 32'h120, 32'h500, 0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         n_checks++;
         if (redirect_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL stall_hold_%0d: got rv=%b busy=%b expected 0/0", k, redirect_valid, busy);
         end
      end
      ex_stall = 0;
      cycle();
      clear_ex();
      n_checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h500) begin
         n_fail++; $display("FAIL stall_release: got rv=%b pc=%h expected 1/500", redirect_valid, redirect_pc);
      end
      pulses = 0;
      repeat (RC + 3) begin
         cycle();
         if (redirect_valid) pulses++;
      end
      n_checks++;
      if (pulses != 0 || mispredict_count !== m_count) begin
         n_fail++; $display("FAIL stall_once: got extra=%0d cnt=%0d expected 0/%0d", pulses, mispredict_count, m_count);
      end
   endtask

   task automatic test_reset_recover();
      int pulses;
      set_ex(1, 0, 1, 0, 1, 32'h140, 32'h700, 0, 32'h0);
      cycle();
      clear_ex();
      cycle();
      n_checks++;
      if (busy !== (RC > 0)) begin
         n_fail++; $display("FAIL rr_in_recover: got busy=%b expected %b", busy, RC > 0);
      end
      #2 rst_n = 0;
      model_reset();
      #1;
      n_checks++;
      if (busy !== 1'b0 || redirect_valid !== 1'b0 || mispredict_count !== 32'h0) begin
         n_fail++; $display("FAIL rr_abort: got busy=%b rv=%b cnt=%0d expected 0/0/0",
                            busy, redirect_valid, mispredict_count);
      end
      @(posedge clk);
      #1 rst_n = 1;
      pulses = 0;
      repeat (4) begin
         cycle();
         if (redirect_valid || busy) pulses++;
      end
      n_checks++;
      if (pulses != 0) begin
         n_fail++; $display("FAIL rr_after_release: got %0d active cycles expected 0", pulses);
      end
   endtask

   task automatic test_random();
      logic [68:0] got, exp;
      int          kind;
      for (int c = 0; c < 400; c++) begin
         if_pc          = 32'($urandom_range(0, 255)) << 2;
         kind           = int'($urandom_range(0, 99));
         ex_valid       = ($urandom_range(0, 3) != 0);
         ex_stall       = ($urandom_range(0, 4) == 0);
         ex_branch      = (kind < 55) || (kind >= 95);
         ex_jump        = (kind >= 55 && kind < 75) || (kind >= 95);
         ex_taken       = ex_jump ? 1'b1 : 1'($urandom_range(0, 1));
         ex_pc          = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : (32'($urandom_range(0, 255)) << 2);
         ex_target      = 32'($urandom_range(0, 255)) << 2;
         ex_pred_taken  = 1'($urandom_range(0, 1));
         ex_pred_target = ($urandom_range(0, 3) != 0) ? ex_target : (32'($urandom_range(0, 255)) << 2);
         cycle();
         got = {redirect_valid, flush_if_id, flush_id_ex, busy, redirect_pc, mispredict_count, pred_taken};
         exp = {m_pulse, m_pulse, m_pulse, (m_busy_left > 0), m_pc, m_count, m_pred(if_pc)};
         n_checks++;
         if (got !== exp) begin
            n_fail++; $display("FAIL random_%0d: got %h expected %h", c, got, exp);
         end
      end
      clear_ex();
   endtask

   initial begin
      test_reset();
      test_beq_mispredict();
      test_bht_train();
      test_wrap();
      test_jal();
      test_stall();
      test_reset_recover();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
- Sequences control-flow recovery around the EX-stage branch evaluator.
- Holds a 2-bit saturating branch history table (BHT) that gives the fetch stage a direction prediction.
- Compares each EX-stage resolution (taken flag from the branch evaluator) with the prediction carried down the pipe.
- On a mismatch it issues a one-cycle PC redirect, flushes IF/ID and ID/EX, and squashes further resolutions for a programmable recovery window.

Parameters:
- INDEX_W, 6, BHT index width; table has 2^INDEX_W entries, indexed by pc[INDEX_W+1:2].
- RECOVER_CYCLES, 1, cycles after the redirect during which resolutions are ignored; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  32  fetch-stage PC for the BHT lookup.
- pred_taken  out  1  combinational: MSB of BHT[if_pc[INDEX_W+1:2]].
- ex_valid  in  1  EX stage holds a real instruction.
- ex_stall  in  1  EX held this cycle; its resolution does not count.
- ex_branch  in  1  conditional branch in EX.
- ex_jump  in  1  JAL/JALR in EX.
- ex_taken  in  1  branch evaluator outcome; 1 for jumps.
- ex_pc  in  32  PC of the EX instruction.
- ex_target  in  32  computed target.
- ex_pred_taken  in  1  direction predicted at fetch.
- ex_pred_target  in  32  target fetched after a predicted-taken instruction.
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_pc.
- redirect_pc  out  32  corrected fetch PC.
- flush_if_id  out  1  squash the IF/ID register; asserted with redirect_valid.
- flush_id_ex  out  1  squash the ID/EX register; asserted with redirect_valid.
- busy  out  1  high in REDIRECT or RECOVER.
- mispredict_count  out  32  number of redirects issued; wraps at 2^32.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE.
  - redirect_valid, flush_if_id, flush_id_ex and busy go to 0.
  - redirect_pc and mispredict_count go to 0.
  - Every BHT entry goes to 2'b01 (weakly not-taken).
  - Reset asserted mid-REDIRECT or mid-RECOVER aborts immediately; no pulse is emitted after release.
- Qualified resolution: res = ex_valid & !ex_stall & (ex_branch | ex_jump) & state==IDLE.
- Mispredict: res & ( (ex_taken != ex_pred_taken) | (ex_taken & ex_pred_taken & ex_target != ex_pred_target) ).
- Corrected PC: ex_target if ex_taken, else ex_pc+4. The +4 is modulo 2^32.
- FSM transitions:
  - IDLE -> REDIRECT on mispredict.
  - REDIRECT -> RECOVER if RECOVER_CYCLES>0, else -> IDLE. REDIRECT always lasts exactly 1 cycle, independent of ex_stall.
  - RECOVER -> IDLE after RECOVER_CYCLES cycles, counted by an internal down-counter loaded on entry.
- Outputs are registered, so latency is 1 cycle:
  - In the cycle after a mispredicting resolution: redirect_valid=1, flush_if_id=1, flush_id_ex=1, redirect_pc=corrected PC, mispredict_count increments.
  - All three pulses deassert in the following cycle.
  - redirect_pc holds its last value when redirect_valid=0.
- busy = (state != IDLE).
- Squash window: in REDIRECT and RECOVER every resolution is ignored, with no BHT update and no redirect. These are wrong-path instructions.
- BHT update:
  - Occurs on res & ex_branch & !ex_jump.
  - ex_taken=1: counter increments, saturating at 3. ex_taken=0: counter decrements, saturating at 0.
  - Jumps never update the BHT.
  - The update is written at the clock edge. A same-cycle lookup at the same index returns the pre-update value (no bypass).
- Stall: while ex_stall=1 in IDLE, a resolution is neither updated nor acted on. It is expected to be re-presented unchanged once the stall drops.
- ex_branch & ex_jump both high is illegal; behaviour is treated as a jump.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0. All outputs 0. mispredict_count=0.
- BEQ at ex_pc=0x200, ex_pred_taken=0, ex_taken=1, ex_target=0x180:
  - Next cycle: redirect_valid=flush_if_id=flush_id_ex=1, redirect_pc=0x180, mispredict_count=1.
  - busy stays high for 1+RECOVER_CYCLES cycles.
- Four correctly predicted taken BNEs at pc=0x40 (pred_target matches) -> no redirect. The counter walks 01->10->11->11. Lookup at 0x40 then gives pred_taken=1.
- Mispredicted not-taken branch at ex_pc=0xFFFFFFFC:
  - redirect_pc=0x00000000 (wrap).
  - Any resolution presented during RECOVER is ignored: no second redirect, no BHT change.
- JAL with ex_pred_taken=1 but ex_pred_target=0x300 ≠ ex_target=0x340 -> redirect_pc=0x340 one cycle later. The BHT is unchanged.
- Stall and reset corner cases:
  - Mispredicting resolution held with ex_stall=1 for 3 cycles -> no redirect. After the stall drops, exactly one redirect.
  - rst_n pulsed low during RECOVER -> busy=0 immediately; no redirect after release.
